// File: rtl/project_spi_register_bridge.sv
// project_spi_register_bridge
// SPI mode-0 slave (MSB first) that acts as the bus initiator for the PWM
// register file. A 16-bit frame is a command byte followed by a data byte.
// The command byte is W, reserved, addr[5:0]. A write frame produces a
// single-cycle o_write_en strobe. A read frame returns i_data on o_miso.
// All SPI pins are oversampled in i_clk, so i_clk must be at least 10x SCLK.
// Optional burst (auto-increment) mode: define PROJECT_SPI_AUTO_INC_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame; waiting for the synchronized CS falling edge
// CMD   | shifting in the command byte (W, reserved, address)
// DATA  | shifting write data in, or read data out on o_miso
// DONE  | frame complete; SCLK edges ignored until CS rises

module project_spi_register_bridge #(
    parameter int ADDRESS_MAX = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_write_en,
    output logic [5:0] o_address,
    output logic [7:0] o_data,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_frame_error
);

    localparam logic [5:0] ADDR_MAX = 6'(ADDRESS_MAX);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [4:0] bit_cnt;
    logic [7:0] rx_sr, tx_sr;
    logic       is_write, miso_en;
    logic       write_req, load_req, inc_req, inc_stage;
    logic       addr_ok, last_rise, partial;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign addr_ok   = (o_address <= ADDR_MAX);
    // bit_cnt == 15 on a DATA rise means this rise completes a data byte
    assign last_rise = (state == DATA) && sclk_rise && (bit_cnt == 5'd15);

`ifdef PROJECT_SPI_AUTO_INC_EN
    // In burst mode bit_cnt runs 9..16 per data byte, so any multiple of 8 is a byte boundary
    assign partial = (bit_cnt[2:0] != 3'd0);
`else
    assign partial = (bit_cnt != 5'd0) && (bit_cnt != 5'd16);
`endif

    assign o_busy = (state != IDLE);
    assign o_miso = (state == DATA) && miso_en && tx_sr[7];

    // Synchronize the SPI pins; CS chain resets low so a frame already running at reset release is never entered
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next-state logic; a CS rising edge returns to IDLE from any state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cs_fall) state_nxt = CMD;
            CMD:  if (sclk_rise && bit_cnt == 5'd7) state_nxt = DATA;
            DATA: begin
`ifdef PROJECT_SPI_AUTO_INC_EN
                state_nxt = DATA;
`else
                if (last_rise) state_nxt = DONE;
`endif
            end
            default: state_nxt = state;
        endcase
        if (cs_rise) state_nxt = IDLE;
    end

    // Shift registers, bit counter and the register-file strobes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bit_cnt       <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            is_write      <= 1'b0;
            miso_en       <= 1'b0;
            write_req     <= 1'b0;
            load_req      <= 1'b0;
            inc_req       <= 1'b0;
            inc_stage     <= 1'b0;
            o_write_en    <= 1'b0;
            o_address     <= '0;
            o_data        <= '0;
            o_frame_error <= 1'b0;
        end else begin
            write_req     <= 1'b0;
            load_req      <= 1'b0;
            inc_req       <= 1'b0;
            inc_stage     <= inc_req;
            o_write_en    <= write_req;
            o_frame_error <= 1'b0;

            if (write_req) o_data <= rx_sr;

            // i_data is combinational on o_address, so load one cycle after the address settles
            if (load_req) begin
                tx_sr   <= addr_ok ? i_data : 8'h00;
                miso_en <= 1'b1;
            end

            // Advance the address after the write strobe has been seen with the old address
            if (inc_stage) begin
                o_address <= (o_address == ADDR_MAX) ? 6'd0 : o_address + 6'd1;
                load_req  <= ~is_write;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        miso_en <= 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_sr   <= {rx_sr[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            o_address <= {rx_sr[4:0], mosi_s};
                            is_write  <= rx_sr[6];
                            load_req  <= ~rx_sr[6];
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_sr     <= {rx_sr[6:0], mosi_s};
`ifdef PROJECT_SPI_AUTO_INC_EN
                        bit_cnt   <= (bit_cnt == 5'd16) ? 5'd9 : bit_cnt + 5'd1;
                        inc_req   <= last_rise;
`else
                        bit_cnt   <= bit_cnt + 5'd1;
`endif
                        write_req <= last_rise && is_write && addr_ok;
                    end
                    // Bit 7 is already on o_miso after the load, so the 8th fall must not shift
                    if (sclk_fall && bit_cnt >= 5'd9 && bit_cnt <= 5'd15)
                        tx_sr <= {tx_sr[6:0], 1'b0};
                end
                default: ;
            endcase

            if (cs_rise) begin
                miso_en       <= 1'b0;
                load_req      <= 1'b0;
                inc_req       <= 1'b0;
                inc_stage     <= 1'b0;
                o_frame_error <= ((state == CMD) || (state == DATA)) && partial;
            end
        end
    end

endmodule

// File: tb/tb_project_spi_register_bridge.sv
// Testbench for project_spi_register_bridge: drives SPI mode-0 frames and
// compares against a frame-level reference model of the register file.
`timescale 1ns/1ps
module tb_project_spi_register_bridge;

    localparam int ADDRESS_MAX = 48;
    localparam int LATENCY     = 4;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_sclk = 1'b0;
    logic       i_cs_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       o_miso, o_write_en, o_busy, o_frame_error;
    logic [5:0] o_address;
    logic [7:0] o_data, i_data;

    logic [7:0] mem     [0:63];
    logic [7:0] ref_mem [0:63];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int err_count = 0;
    int wr_cyc = 0;
    int rise_cyc = 0;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int          exp_wr, exp_err;
    logic [5:0]  exp_waddr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_rd_q[$];
    logic [31:0] miso_cap;

    project_spi_register_bridge #(.ADDRESS_MAX(ADDRESS_MAX), .SYNC_STAGES(2)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_sclk        (i_sclk),
        .i_cs_n        (i_cs_n),
        .i_mosi        (i_mosi),
        .o_miso        (o_miso),
        .o_write_en    (o_write_en),
        .o_address     (o_address),
        .o_data        (o_data),
        .i_data        (i_data),
        .o_busy        (o_busy),
        .o_frame_error (o_frame_error)
    );

    always #5 i_clk = ~i_clk;

    assign i_data = mem[o_address];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Register file behind the bridge plus pulse counters
    always @(negedge i_clk) begin
        if (o_write_en) begin
            wr_count++;
            wr_cyc  = cyc;
            wr_addr = o_address;
            wr_data = o_data;
            mem[o_address] = o_data;
        end
        if (o_frame_error) err_count++;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    // Frame-level model: decides writes, reads and abort from the bit stream alone
    task automatic model_frame(input logic [31:0] bits, input int nbits);
        int a, nbytes;
        logic [7:0] d;
        exp_wr = 0;
        exp_rd_q.delete();
        a = int'(bits[29:24]);
`ifdef PROJECT_SPI_AUTO_INC_EN
        exp_err = (nbits % 8 != 0) ? 1 : 0;
        nbytes  = (nbits / 8) - 1;
`else
        exp_err = (nbits >= 1 && nbits <= 15) ? 1 : 0;
        nbytes  = (nbits >= 16) ? 1 : 0;
`endif
        for (int k = 0; k < nbytes; k++) begin
            d = bits[23-8*k -: 8];
            if (bits[31]) begin
                if (a <= ADDRESS_MAX) begin
                    ref_mem[a] = d;
                    exp_wr++;
                    exp_waddr = 6'(a);
                    exp_wdata = d;
                end
            end else begin
                exp_rd_q.push_back((a <= ADDRESS_MAX) ? ref_mem[a] : 8'h00);
            end
            a = (a == ADDRESS_MAX) ? 0 : (a + 1) % 64;
        end
    endtask

    task automatic cs_low();
        @(negedge i_clk);
        i_cs_n = 1'b0;
        repeat (6) @(negedge i_clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge i_clk);
        i_cs_n = 1'b1;
        repeat (10) @(negedge i_clk);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            i_mosi = bits[31-i];
            repeat (8) @(negedge i_clk);
            miso_cap[31-i] = o_miso;
            i_sclk   = 1'b1;
            rise_cyc = cyc;
            repeat (8) @(negedge i_clk);
            i_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [31:0] bits, input int nbits);
        cs_low();
        shift_bits(bits, 0, nbits);
        cs_high();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", o_miso); end
        checks++; if (o_write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en got %b exp 0", o_write_en); end
        checks++; if (o_address !== 6'h00) begin errors++; $display("FAIL reset_address got %h exp 00", o_address); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", o_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b exp 0", o_frame_error); end
        i_reset = 1'b0;
        repeat (6) @(negedge i_clk);
        checks++; if (err_count !== 0) begin errors++; $display("FAIL reset_release_error got %0d exp 0", err_count); end
    endtask

    task automatic test_read_basic();
        int w0;
        w0 = wr_count;
        model_frame(32'h0500_0000, 16);
        run_frame(32'h0500_0000, 16);
        checks++; if (miso_cap[23:16] !== 8'hA7) begin errors++; $display("FAIL read_basic got %h exp a7", miso_cap[23:16]); end
        checks++; if (miso_cap[23:16] !== exp_rd_q[0]) begin errors++; $display("FAIL read_basic_model got %h exp %h", miso_cap[23:16], exp_rd_q[0]); end
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL read_no_write got %0d exp 0", wr_count - w0); end
        checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL read_miso_idle got %b exp 0", o_miso); end
    endtask

    task automatic test_write_basic();
        int w0, e0;
        w0 = wr_count;
        e0 = err_count;
        model_frame(32'h853C_0000, 16);
        cs_low();
        shift_bits(32'h853C_0000, 0, 8);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame got %b exp 1", o_busy); end
        shift_bits(32'h853C_0000, 8, 8);
        cs_high();
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL write_count got %0d exp 1", wr_count - w0); end
        checks++; if (wr_addr !== 6'h05) begin errors++; $display("FAIL write_addr got %h exp 05", wr_addr); end
        checks++; if (wr_data !== 8'h3C) begin errors++; $display("FAIL write_data got %h exp 3c", wr_data); end
        checks++; if (wr_cyc - rise_cyc !== LATENCY) begin errors++; $display("FAIL write_latency got %0d exp %0d", wr_cyc - rise_cyc, LATENCY); end
        checks++; if (err_count - e0 !== 0) begin errors++; $display("FAIL write_no_error got %0d exp 0", err_count - e0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_after_frame got %b exp 0", o_busy); end
        checks++; if (o_data !== 8'h3C) begin errors++; $display("FAIL data_hold got %h exp 3c", o_data); end
    endtask

    task automatic test_out_of_range();
        int w0;
        w0 = wr_count;
        model_frame(32'hB5FF_0000, 16);
        run_frame(32'hB5FF_0000, 16);
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL oor_write got %0d exp 0", wr_count - w0); end
        checks++; if (o_data !== 8'h3C) begin errors++; $display("FAIL oor_data_hold got %h exp 3c", o_data); end
        model_frame(32'h3500_0000, 16);
        run_frame(32'h3500_0000, 16);
        checks++; if (miso_cap[23:16] !== 8'h00) begin errors++; $display("FAIL oor_read got %h exp 00", miso_cap[23:16]); end
    endtask

    task automatic test_abort();
        int w0, e0;
        w0 = wr_count;
        e0 = err_count;
        cs_low();
        shift_bits(32'h8C99_0000, 0, 11);
        cs_high();
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL abort_write got %0d exp 0", wr_count - w0); end
        checks++; if (err_count - e0 !== 1) begin errors++; $display("FAIL abort_error got %0d exp 1", err_count - e0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", o_busy); end
        model_frame(32'h8C99_0000, 16);
        run_frame(32'h8C99_0000, 16);
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL abort_recover got %0d exp 1", wr_count - w0); end
        checks++; if (mem[12] !== 8'h99) begin errors++; $display("FAIL abort_recover_data got %h exp 99", mem[12]); end
    endtask

    task automatic test_reset_mid();
        int w0, e0;
        w0 = wr_count;
        e0 = err_count;
        cs_low();
        shift_bits(32'h8A55_0000, 0, 12);
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", o_busy); end
        i_reset = 1'b0;
        shift_bits(32'h8A55_0000, 12, 4);
        cs_high();
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL rst_mid_write got %0d exp 0", wr_count - w0); end
        checks++; if (err_count - e0 !== 0) begin errors++; $display("FAIL rst_mid_error got %0d exp 0", err_count - e0); end
        checks++; if (o_address !== 6'h00) begin errors++; $display("FAIL rst_mid_address got %h exp 00", o_address); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", o_data); end
        checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL rst_mid_miso got %b exp 0", o_miso); end
        model_frame(32'h8A55_0000, 16);
        run_frame(32'h8A55_0000, 16);
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL rst_mid_recover got %0d exp 1", wr_count - w0); end
        checks++; if (mem[10] !== 8'h55) begin errors++; $display("FAIL rst_mid_recover_data got %h exp 55", mem[10]); end
    endtask

    task automatic test_burst();
        int w0, e0;
        w0 = wr_count;
        e0 = err_count;
        model_frame(32'hB011_2200, 24);
        run_frame(32'hB011_2200, 24);
        checks++; if (mem[48] !== 8'h11) begin errors++; $display("FAIL burst_reg48 got %h exp 11", mem[48]); end
`ifdef PROJECT_SPI_AUTO_INC_EN
        checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL burst_count got %0d exp 2", wr_count - w0); end
        checks++; if (mem[0] !== 8'h22) begin errors++; $display("FAIL burst_wrap_reg0 got %h exp 22", mem[0]); end
`else
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL burst_count got %0d exp 1", wr_count - w0); end
        checks++; if (mem[0] !== ref_mem[0]) begin errors++; $display("FAIL burst_reg0_untouched got %h exp %h", mem[0], ref_mem[0]); end
`endif
        checks++; if (err_count - e0 !== 0) begin errors++; $display("FAIL burst_error got %0d exp 0", err_count - e0); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            logic [31:0] bits;
            logic [5:0]  addr;
            int nbits, sel, w0, e0;
            bits = $urandom;
            addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(49, 63)) : 6'($urandom_range(0, 48));
            bits[29:24] = addr;
            sel = int'($urandom_range(0, 5));
            nbits = (sel < 3) ? 16 : (sel == 3) ? 24 : int'($urandom_range(1, 23));
            w0 = wr_count;
            e0 = err_count;
            model_frame(bits, nbits);
            run_frame(bits, nbits);
            checks++; if (wr_count - w0 !== exp_wr) begin errors++; $display("FAIL rnd%0d_write_count got %0d exp %0d", f, wr_count - w0, exp_wr); end
            checks++; if (err_count - e0 !== exp_err) begin errors++; $display("FAIL rnd%0d_frame_error got %0d exp %0d", f, err_count - e0, exp_err); end
            if (exp_wr > 0) begin
                checks++; if (wr_addr !== exp_waddr || wr_data !== exp_wdata) begin errors++; $display("FAIL rnd%0d_write got %h:%h exp %h:%h", f, wr_addr, wr_data, exp_waddr, exp_wdata); end
            end
            for (int k = 0; k < exp_rd_q.size(); k++) begin
                checks++; if (miso_cap[23-8*k -: 8] !== exp_rd_q[k]) begin errors++; $display("FAIL rnd%0d_read%0d got %h exp %h", f, k, miso_cap[23-8*k -: 8], exp_rd_q[k]); end
            end
        end
    endtask

    task automatic test_regfile_final();
        for (int i = 0; i < 64; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL regfile[%0d] got %h exp %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[5]      = 8'hA7;
        ref_mem[5]  = 8'hA7;
        mem[53]     = 8'h5A;
        ref_mem[53] = 8'h5A;
        test_reset();
        test_read_basic();
        test_write_basic();
        test_out_of_range();
        test_abort();
        test_reset_mid();
        test_burst();
        test_random();
        test_regfile_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
